// File: rtl/ip_codma_dp_pkg.sv
// rtl/ip_codma_dp_pkg.sv - shared types and constants for the codma data-phase engine
package ip_codma_dp_pkg;

    localparam int DP_ADDR_W  = 32;
    localparam int BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_READ,
        DP_WRITE,
        DP_ERROR
    } dp_state_t;

    typedef logic [1:0] dp_beat_cnt_t;

    typedef struct packed {
        logic                 read;
        logic                 write;
        logic [DP_ADDR_W-1:0] addr;
        dp_beat_cnt_t         size;
    } dp_entry_t;

endpackage

// File: rtl/ip_codma_dp_engine_addr_gen.sv
// rtl/ip_codma_dp_engine_addr_gen.sv - beat address and beat counter for one burst
module ip_codma_dp_addr_gen
    import ip_codma_dp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRIDE = BEAT_BYTES
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              beat_done_i,
    output logic [ADDR_W-1:0] beat_addr_o,
    output logic              last_beat_o
);

    logic [ADDR_W-1:0] addr_q;
    dp_beat_cnt_t      size_q;
    dp_beat_cnt_t      cnt_q;

    // Load wins over increment so a back-to-back capture starts the new burst cleanly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            size_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            size_q <= size_i;
            cnt_q  <= '0;
        end else if (beat_done_i) begin
            addr_q <= addr_q + ADDR_W'(STRIDE);
            cnt_q  <= last_beat_o ? '0 : cnt_q + 2'd1;
        end
    end

    assign beat_addr_o = addr_q;
    assign last_beat_o = (cnt_q == size_q);

endmodule

// File: rtl/ip_codma_dp_engine.sv
// rtl/ip_codma_dp_engine.sv - codma data-phase engine; CODMA_DP_BACK2BACK_EN removes the inter-burst idle bubble
module ip_codma_dp_engine
    import ip_codma_dp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [CNT_W-1:0]  ap_fifo_count_i,
    input  logic              ap_read_i,
    input  logic              ap_write_i,
    input  logic [ADDR_W-1:0] ap_addr_i,
    input  logic [1:0]        ap_size_i,
    output logic              fifo_rd_next_o,
    input  logic              bus_ready_i,
    input  logic              bus_error_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_wvalid_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_data_valid_i,
    output logic              wr_data_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_data_valid_o,
    output logic [ADDR_W-1:0] dp_beat_addr_o,
    output logic              dp_busy_o,
    output logic              dp_error_o,
    input  logic              err_clear_i
);

    dp_state_t         state_q, state_d;
    logic              err_q, err_d;
    logic              wvalid_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              rst_hold_q;
    logic              capture;
    logic              beat_done;
    logic              beat_err;
    logic              last_beat;
    dp_entry_t         head;

    always_comb begin
        head       = '0;
        head.read  = ap_read_i;
        head.write = ap_write_i;
        head.addr  = DP_ADDR_W'(ap_addr_i);
        head.size  = ap_size_i;
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        capture   = 1'b0;
        beat_done = 1'b0;
        beat_err  = 1'b0;
        if (err_clear_i) begin
            err_d = 1'b0;
        end
        case (state_q)
            DP_IDLE:  capture = (ap_fifo_count_i != '0) && !rst_hold_q;
            DP_READ: begin
                beat_done = bus_ready_i && !bus_error_i;
                beat_err  = bus_ready_i && bus_error_i;
            end
            DP_WRITE: begin
                beat_done = wvalid_q && bus_ready_i && !bus_error_i;
                beat_err  = wvalid_q && bus_ready_i && bus_error_i;
            end
            DP_ERROR: begin
                if (err_clear_i) begin
                    state_d = DP_IDLE;
                end
            end
            default:  state_d = DP_IDLE;
        endcase
        if (beat_err) begin
            state_d = DP_ERROR;
            err_d   = 1'b1;
        end else if (beat_done && last_beat) begin
            state_d = DP_IDLE;
`ifdef CODMA_DP_BACK2BACK_EN
            capture = (ap_fifo_count_i != '0);
`endif
        end
        // Illegal head entries are still popped so the FIFO cannot wedge on them.
        if (capture) begin
            if (head.read && !head.write) begin
                state_d = DP_READ;
            end else if (head.write && !head.read) begin
                state_d = DP_WRITE;
            end else begin
                state_d = DP_ERROR;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= DP_IDLE;
            err_q      <= 1'b0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            rst_hold_q <= 1'b0;
            rvalid_q   <= (state_q == DP_READ) && beat_done;
            if ((state_q == DP_READ) && beat_done) begin
                rdata_q <= bus_rdata_i;
            end
            if (beat_done || beat_err) begin
                wvalid_q <= 1'b0;
            end else if (wr_data_ready_o && wr_data_valid_i) begin
                wvalid_q <= 1'b1;
                wdata_q  <= wr_data_i;
            end
        end
    end

    ip_codma_dp_addr_gen #(
        .ADDR_W (ADDR_W),
        .STRIDE (DATA_W / 8)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (capture && !reset_i),
        .addr_i      (ADDR_W'(head.addr)),
        .size_i      (head.size),
        .beat_done_i (beat_done),
        .beat_addr_o (dp_beat_addr_o),
        .last_beat_o (last_beat)
    );

    assign fifo_rd_next_o  = capture && !reset_i;
    assign wr_data_ready_o = (state_q == DP_WRITE) && !wvalid_q;
    assign bus_wvalid_o    = wvalid_q;
    assign bus_wdata_o     = wdata_q;
    assign rd_data_o       = rdata_q;
    assign rd_data_valid_o = rvalid_q;
    assign dp_busy_o       = (state_q != DP_IDLE);
    assign dp_error_o      = err_q;

endmodule
